demux_nway_buffered: RTL and testbench
======================================

Name: demux_nway_buffered

Overview:
- Parametrised successor to the 8-way single-bit demultiplexer.
- Routes a WIDTH-bit word to one of NUM_OUT output channels, or to all of them in broadcast mode.
- Uses a valid/ready handshake and a one-entry register slot per output channel.
- Sits between a producer and NUM_OUT independent consumers, e.g. the memory-mapped device fan-out, where consumers can stall independently.

Parameters:
- WIDTH, 16, data word width in bits (>=1)
- NUM_OUT, 8, number of output channels (2..64, need not be a power of two)
- SEL_W, $clog2(NUM_OUT), width of the select field (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  SEL_W  destination channel index (unicast)
- in_bcast  input  1  1 = deliver to all channels; in_sel ignored
- in_valid  input  1  producer offers in_data/in_sel/in_bcast
- in_ready  output  1  block accepts this cycle
- out_data  output  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  NUM_OUT  channel k slot holds a word
- out_ready  input  NUM_OUT  consumer k takes its word this cycle
- drop  output  1  one-cycle pulse: a unicast word with in_sel >= NUM_OUT was accepted and discarded

Behaviour:
- State: per channel k, full[k] and data register dreg[k]. out_valid[k] = full[k]; out_data slice k = dreg[k].
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer on channel k: out_valid[k] & out_ready[k] at a rising edge.
- can_accept[k] = !full[k] | out_ready[k]. Same-cycle drain-and-refill is allowed, giving one word per cycle per channel.
- in_ready is combinational from in_sel, in_bcast and out_ready. No combinational path from in_valid to in_ready.
  - reset=1: in_ready = 0.
  - bcast=1: in_ready = AND over all k of can_accept[k] (all-or-nothing delivery).
  - bcast=0, in_sel < NUM_OUT: in_ready = can_accept[in_sel].
  - bcast=0, in_sel >= NUM_OUT: in_ready = 1. Word is accepted and discarded.
- On an input transfer, every target channel k loads dreg[k] <= in_data and sets full[k] <= 1. Targets are all k for broadcast, channel in_sel for unicast.
- Latency: a word accepted at edge t is visible on out_valid/out_data after edge t. One cycle, no combinational in->out data path.
- On an output transfer on k with no simultaneous load on k: full[k] <= 0.
- dreg[k] holds its value after draining. It changes only on a load. out_data is stable while out_valid=1 and out_ready=0.
- drop is registered:
  - drop <= 1 for exactly the cycle after an out-of-range unicast input transfer, else 0.
  - Never asserts when NUM_OUT is a power of two.
- Channels are independent: a stalled channel blocks only unicasts to it and all broadcasts.
- Reset (synchronous, any time, including mid-stream):
  - full <= 0, all dreg <= 0, drop <= 0.
  - Buffered words are discarded and no transfer occurs in that cycle.
  - After reset deasserts: all out_valid = 0, out_data = 0, drop = 0.
- Producer rule (checked by assertion): while in_valid=1 and in_ready=0, in_data, in_sel and in_bcast are held stable.

Test Plan:
- NUM_OUT=8, WIDTH=16, out_ready all 1; unicast 0x1000+k to sel=k for k=0..7 on consecutive cycles -> out_valid[k] pulses 1 cycle after each accept, slice k = 0x1000+k, in_ready constantly 1, drop never 1.
- out_ready[3]=0; send 0xAAAA to sel=3, then 0xBBBB to sel=3 -> first accepted, in_ready=0 for second while held. A 0x5555 to sel=5 is still accepted meanwhile. Raise out_ready[3] -> 0xAAAA taken and 0xBBBB loaded at the same edge, and slice 3 shows 0xBBBB next cycle.
- Broadcast 0x00FF with out_ready[6]=0 and slot 6 full -> in_ready=0, no channel loads. Release out_ready[6] -> all 8 out_valid=1 with 0x00FF the following cycle.
- NUM_OUT=6 (SEL_W=3); unicast 0x1234 with sel=7 -> in_ready=1, drop=1 for one cycle, no out_valid change. sel=5 -> channel 5 receives 0x1234, drop=0.
- Fill channels 0,2,4 with out_ready=0, assert reset for 1 cycle with in_valid=1 -> in_ready=0 during reset. Next cycle out_valid=0, out_data=0, drop=0, and nothing accepted.
- Random stress: random in_valid/in_sel/in_bcast/out_ready over 10k cycles against a scoreboard -> per-channel word order preserved, no loss except counted drops, no duplication.

Source files
------------

// File: rtl/demux_nway_buffered.sv
// rtl/demux_nway_buffered.sv - valid/ready 1:N word demux with broadcast and a one-entry slot per channel
module demux_nway_buffered #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     drop
);

  logic [NUM_OUT-1:0]            full_q, full_d;
  logic [NUM_OUT-1:0][WIDTH-1:0] dreg_q, dreg_d;
  logic                          drop_q, drop_d;
  logic [NUM_OUT-1:0]            can_accept, sel_oh, load;
  logic                          sel_in_range, in_fire;

  // A power-of-two channel count leaves no unused select codes, so nothing can be dropped.
  generate
    if (NUM_OUT == (1 << SEL_W)) begin : g_pow2
      assign sel_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(NUM_OUT);
      assign sel_in_range = ({1'b0, in_sel} < SEL_LIMIT);
    end
  endgenerate

  always_comb begin
    can_accept = ~full_q | out_ready;
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_oh[k] = (in_sel == SEL_W'(k));
    end

    if (reset) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &can_accept;
    end else if (sel_in_range) begin
      in_ready = |(sel_oh & can_accept);
    end else begin
      in_ready = 1'b1;
    end

    in_fire = in_valid & in_ready;
    load    = in_fire ? (in_bcast ? {NUM_OUT{1'b1}} : sel_oh) : {NUM_OUT{1'b0}};
    drop_d  = in_fire & ~in_bcast & ~sel_in_range;
    full_d  = (full_q & ~out_ready) | load;

    dreg_d = dreg_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (load[k]) dreg_d[k] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      dreg_q <= '0;
      drop_q <= 1'b0;
    end else begin
      full_q <= full_d;
      dreg_q <= dreg_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = dreg_q;
  assign drop      = drop_q;

  a_producer_hold: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=>
      (!in_valid || ($stable(in_data) && $stable(in_sel) && $stable(in_bcast))));

endmodule

// File: tb/tb_demux_nway_buffered.sv
// tb/tb_demux_nway_buffered.sv - scoreboard bench for demux_nway_buffered (8-way and 6-way instances)
module tb_demux_nway_buffered;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]  id8 = '0;
  logic [2:0]   is8 = '0;
  logic         ib8 = 1'b0, iv8 = 1'b0;
  logic         ir8, dr8;
  logic [127:0] od8;
  logic [7:0]   ov8;
  logic [7:0]   or8 = '0;

  logic [15:0]  id6 = '0;
  logic [2:0]   is6 = '0;
  logic         ib6 = 1'b0, iv6 = 1'b0;
  logic         ir6, dr6;
  logic [95:0]  od6;
  logic [5:0]   ov6;
  logic [5:0]   or6 = '0;

  demux_nway_buffered #(.WIDTH(16), .NUM_OUT(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_data(id8), .in_sel(is8), .in_bcast(ib8),
    .in_valid(iv8), .in_ready(ir8), .out_data(od8), .out_valid(ov8),
    .out_ready(or8), .drop(dr8)
  );

  demux_nway_buffered #(.WIDTH(16), .NUM_OUT(6)) u_dut6 (
    .clk(clk), .reset(reset), .in_data(id6), .in_sel(is6), .in_bcast(ib6),
    .in_valid(iv6), .in_ready(ir6), .out_data(od6), .out_valid(ov6),
    .out_ready(or6), .drop(dr6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channels 0..7 belong to the 8-way instance, 8..13 to the 6-way instance.
  logic [15:0] sbq[14][$];
  logic pend8 = 1'b0, pend6 = 1'b0;

  task automatic sb_step(input string tag, input int base, input int n,
                         input logic [7:0] ov, input logic [7:0] ordy, input logic [127:0] od,
                         input logic iv, input logic ir, input logic ib, input logic [2:0] is,
                         input logic [15:0] id, input logic dr, input logic rst,
                         input logic pend_in, output logic pend_out);
    logic exp_rdy, all_ok;
    check({tag, "_drop"}, dr, pend_in);
    all_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, ov[k], sbq[base+k].size() != 0);
      if (sbq[base+k].size() != 0 && !ordy[k]) all_ok = 1'b0;
    end
    if (rst) exp_rdy = 1'b0;
    else if (ib) exp_rdy = all_ok;
    else if (int'(is) < n) exp_rdy = (sbq[base+int'(is)].size() == 0) || ordy[is];
    else exp_rdy = 1'b1;
    check({tag, "_rdy"}, ir, exp_rdy);
    pend_out = 1'b0;
    if (rst) begin
      for (int k = 0; k < n; k++) sbq[base+k].delete();
    end else begin
      for (int k = 0; k < n; k++) begin
        if (ov[k] && ordy[k]) begin
          if (sbq[base+k].size() == 0) check({tag, "_sb_empty"}, sbq[base+k].size(), 1);
          else check({tag, "_data"}, od[k*16 +: 16], sbq[base+k].pop_front());
        end
      end
      if (iv && ir) begin
        if (ib) for (int k = 0; k < n; k++) sbq[base+k].push_back(id);
        else if (int'(is) < n) sbq[base+int'(is)].push_back(id);
        else pend_out = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    sb_step("u8", 0, 8, ov8, or8, od8, iv8, ir8, ib8, is8, id8, dr8, reset, pend8, pend8);
    sb_step("u6", 8, 6, {2'b0, ov6}, {2'b0, or6}, {32'b0, od6}, iv6, ir6, ib6, is6, id6,
            dr6, reset, pend6, pend6);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [15:0] d, input logic [2:0] s, input logic b, output int waited);
    waited = 0;
    id8 = d; is8 = s; ib8 = b; iv8 = 1'b1;
    @(negedge clk);
    while (!ir8 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ir8) check("send8_timeout", ir8, 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int  w;
  logic acc8, acc6;

  initial begin
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", ov8, 8'h00);
    check("rst_data", od8, 128'h0);
    check("rst_drop", dr8, 1'b0);
    step();

    // Unicast stream, all consumers ready.
    or8 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      send8(16'(16'h1000 + k), 3'(k), 1'b0, w);
      check("t1_wait", w, 0);
    end
    iv8 = 1'b0;
    @(negedge clk);
    check("t1_last_valid", ov8, 8'h80);
    check("t1_last_data", od8[127:112], 16'h1007);
    step(); step();

    // Stalled channel 3 blocks only traffic to itself.
    or8 = 8'hF7;
    send8(16'hAAAA, 3'd3, 1'b0, w);
    id8 = 16'hBBBB; is8 = 3'd3; ib8 = 1'b0; iv8 = 1'b1;
    @(negedge clk); check("t2_hold0", ir8, 1'b0);
    step();
    @(negedge clk); check("t2_hold1", ir8, 1'b0);
    step();
    iv8 = 1'b0;
    step();
    send8(16'h5555, 3'd5, 1'b0, w);
    check("t2_other_wait", w, 0);
    id8 = 16'hBBBB; is8 = 3'd3; iv8 = 1'b1;
    @(negedge clk); check("t2_hold2", ir8, 1'b0);
    step();
    or8 = 8'hFF;
    @(negedge clk); check("t2_release", ir8, 1'b1);
    step();
    iv8 = 1'b0; or8 = 8'hF7;
    @(negedge clk);
    check("t2_v3", ov8[3], 1'b1);
    check("t2_d3", od8[63:48], 16'hBBBB);
    step();

    // Broadcast is all-or-nothing.
    or8 = 8'hBF;
    send8(16'h6666, 3'd6, 1'b0, w);
    id8 = 16'h00FF; ib8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    check("t3_stall_rdy0", ir8, 1'b0);
    check("t3_stall_v0", ov8, 8'h40);
    step();
    @(negedge clk);
    check("t3_stall_rdy1", ir8, 1'b0);
    check("t3_stall_v1", ov8, 8'h40);
    step();
    or8 = 8'hFF;
    @(negedge clk); check("t3_release", ir8, 1'b1);
    step();
    iv8 = 1'b0; ib8 = 1'b0; or8 = 8'h00;
    @(negedge clk);
    check("t3_all_valid", ov8, 8'hFF);
    check("t3_all_data", od8, {8{16'h00FF}});
    step();
    or8 = 8'hFF;
    step(); step();

    // Out-of-range select on the 6-way instance.
    or6 = 6'h3F;
    id6 = 16'h1234; is6 = 3'd7; ib6 = 1'b0; iv6 = 1'b1;
    @(negedge clk); check("t4_oor_rdy", ir6, 1'b1);
    step();
    iv6 = 1'b0;
    @(negedge clk);
    check("t4_drop_hi", dr6, 1'b1);
    check("t4_no_valid", ov6, 6'h00);
    step();
    @(negedge clk); check("t4_drop_lo", dr6, 1'b0);
    step();
    is6 = 3'd5; iv6 = 1'b1;
    @(negedge clk); check("t4_in_rdy", ir6, 1'b1);
    step();
    iv6 = 1'b0; or6 = 6'h00;
    @(negedge clk);
    check("t4_v5", ov6, 6'h20);
    check("t4_d5", od6[95:80], 16'h1234);
    check("t4_drop_none", dr6, 1'b0);
    step();
    or6 = 6'h3F;
    step();

    // Mid-stream reset discards buffered words and the offered word.
    or8 = 8'h00;
    send8(16'h0A00, 3'd0, 1'b0, w);
    send8(16'h0A02, 3'd2, 1'b0, w);
    send8(16'h0A04, 3'd4, 1'b0, w);
    id8 = 16'h7777; is8 = 3'd1; iv8 = 1'b1; reset = 1'b1;
    @(negedge clk); check("t5_rst_rdy", ir8, 1'b0);
    step();
    reset = 1'b0; iv8 = 1'b0;
    @(negedge clk);
    check("t5_valid", ov8, 8'h00);
    check("t5_data", od8, 128'h0);
    check("t5_drop", dr8, 1'b0);
    step();

    // Random stress on both instances; a stalled offer is held unchanged.
    acc8 = 1'b1; acc6 = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < 8; k++) or8[k] = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 6; k++) or6[k] = ($urandom_range(0, 9) < 7);
      if (!(iv8 && !acc8)) begin
        iv8 = ($urandom_range(0, 9) < 6);
        ib8 = ($urandom_range(0, 9) == 0);
        is8 = 3'($urandom_range(0, 7));
        id8 = 16'($urandom);
      end
      if (!(iv6 && !acc6)) begin
        iv6 = ($urandom_range(0, 9) < 6);
        ib6 = ($urandom_range(0, 9) == 0);
        is6 = 3'($urandom_range(0, 7));
        id6 = 16'($urandom);
      end
      @(negedge clk);
      acc8 = ir8;
      acc6 = ir6;
      step();
    end
    reset = 1'b0; iv8 = 1'b0; iv6 = 1'b0; or8 = 8'hFF; or6 = 6'h3F;
    step(); step(); step();
    @(negedge clk);
    check("end_empty8", ov8, 8'h00);
    check("end_empty6", ov6, 6'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
